// File: rtl/score_display_renderer.sv
// Multi-player score overlay: binary scores -> BCD (sequential double dabble) -> 7-segment pixels.
// New scores are captured on a vblank rising edge and committed to the display before active video.
module score_display_renderer #(
  parameter int NUM_PLAYERS  = 2,
  parameter int SCORE_W      = 7,
  parameter int DIGITS       = 2,
  parameter int SCALE_LOG2   = 0,
  parameter int X0           = 128,
  parameter int PLAYER_DX    = 192,
  parameter int DIGIT_DX     = 32,
  parameter int Y0           = 32,
  parameter int BLANK_LZ     = 1,
  parameter int BLINK_FRAMES = 16
) (
  input  logic                           clk7_159,
  input  logic                           reset,
  input  logic [8:0]                     hcnt,
  input  logic [8:0]                     vcnt,
  input  logic                           vblank,
  input  logic [NUM_PLAYERS*SCORE_W-1:0] score_in,
  input  logic                           score_load,
  input  logic                           blink_en,
  output logic                           busy,
  output logic                           score
);

  localparam int S      = 1 << SCALE_LOG2;
  localparam int NB_RAW = (SCORE_W + 3) / 3;  // enough nibbles for 2^SCORE_W-1
  localparam int NB     = (NB_RAW > DIGITS) ? NB_RAW : DIGITS;
  localparam int PW     = (NUM_PLAYERS > 1) ? $clog2(NUM_PLAYERS) : 1;
  localparam int CW     = (SCORE_W > 1) ? $clog2(SCORE_W) : 1;
  localparam int FW     = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic signed [15:0] YC = 16'(Y0);

  typedef enum logic [1:0] {ST_IDLE, ST_CONV, ST_COMMIT} state_t;

  state_t                r_state, w_state_next;
  logic                  w_capture;
  logic                  r_vblank_d;
  logic                  w_vb_rise;
  logic                  r_pending;
  logic [SCORE_W-1:0]    r_cap    [NUM_PLAYERS];
  logic [4*DIGITS-1:0]   r_shadow [NUM_PLAYERS];
  logic [4*DIGITS-1:0]   r_disp   [NUM_PLAYERS];
  logic [PW-1:0]         r_player, w_next_idx;
  logic [CW-1:0]         r_bitcnt;
  logic [SCORE_W-1:0]    r_bin;
  logic [4*NB-1:0]       r_bcd, w_bcd_adj, w_bcd_next;
  logic                  w_over;
  logic [4*DIGITS-1:0]   w_sat_val;
  logic                  w_last_bit, w_last_player;
  logic [FW-1:0]         r_frame_cnt;
  logic                  r_hidden;
  logic                  w_frame_wrap;
  logic [NUM_PLAYERS-1:0] w_player_hit;
  logic signed [15:0]    w_dy, w_w;
  logic                  w_in_y;

  function automatic logic [6:0] f_seg7(input logic [3:0] d);
    // bit order {g,f,e,d,c,b,a}
    case (d)
      4'd0:    f_seg7 = 7'h3F;
      4'd1:    f_seg7 = 7'h06;
      4'd2:    f_seg7 = 7'h5B;
      4'd3:    f_seg7 = 7'h4F;
      4'd4:    f_seg7 = 7'h66;
      4'd5:    f_seg7 = 7'h6D;
      4'd6:    f_seg7 = 7'h7D;
      4'd7:    f_seg7 = 7'h07;
      4'd8:    f_seg7 = 7'h7F;
      4'd9:    f_seg7 = 7'h6F;
      default: f_seg7 = 7'h00;
    endcase
  endfunction

  assign w_vb_rise     = vblank & ~r_vblank_d;
  assign w_last_bit    = (r_bitcnt == CW'(SCORE_W - 1));
  assign w_last_player = (r_player == PW'(NUM_PLAYERS - 1));
  assign w_next_idx    = w_last_player ? '0 : r_player + 1'b1;
  assign w_frame_wrap  = (r_frame_cnt == FW'(BLINK_FRAMES - 1));

  always_ff @(posedge clk7_159) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_capture    = 1'b0;
    busy         = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_vb_rise && r_pending) begin
          w_capture    = 1'b1;
          w_state_next = ST_CONV;
        end
      end
      ST_CONV: begin
        busy = 1'b1;
        if (w_last_bit && w_last_player) w_state_next = ST_COMMIT;
      end
      ST_COMMIT: begin
        busy         = 1'b1;
        w_state_next = ST_IDLE;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // Add-3 on every nibble >= 5, then shift the next binary bit in at the bottom.
  generate
    for (genvar gi = 0; gi < NB; gi++) begin : g_dd
      assign w_bcd_adj[gi*4 +: 4] = (r_bcd[gi*4 +: 4] >= 4'd5) ? r_bcd[gi*4 +: 4] + 4'd3
                                                              : r_bcd[gi*4 +: 4];
    end
    if (NB > DIGITS) begin : g_over
      assign w_over = |w_bcd_next[4*NB-1:4*DIGITS];
    end else begin : g_no_over
      assign w_over = 1'b0;
    end
  endgenerate

  assign w_bcd_next = {w_bcd_adj[4*NB-2:0], r_bin[SCORE_W-1]};
  assign w_sat_val  = w_over ? {DIGITS{4'h9}} : w_bcd_next[4*DIGITS-1:0];

  always_ff @(posedge clk7_159) begin
    if (reset) begin
      r_vblank_d <= 1'b0;
      r_pending  <= 1'b0;
      r_player   <= '0;
      r_bitcnt   <= '0;
      r_bin      <= '0;
      r_bcd      <= '0;
      for (int p = 0; p < NUM_PLAYERS; p++) begin
        r_cap[p]    <= '0;
        r_shadow[p] <= '0;
        r_disp[p]   <= '0;
      end
    end else begin
      r_vblank_d <= vblank;
      if (score_load)     r_pending <= 1'b1;
      else if (w_capture) r_pending <= 1'b0;
      if (w_capture) begin
        for (int p = 0; p < NUM_PLAYERS; p++) r_cap[p] <= score_in[p*SCORE_W +: SCORE_W];
        r_player <= '0;
        r_bitcnt <= '0;
        r_bcd    <= '0;
        r_bin    <= score_in[SCORE_W-1:0];
      end else if (r_state == ST_CONV) begin
        if (w_last_bit) begin
          r_shadow[r_player] <= w_sat_val;
          r_player           <= w_next_idx;
          r_bitcnt           <= '0;
          r_bcd              <= '0;
          r_bin              <= r_cap[w_next_idx];
        end else begin
          r_bcd    <= w_bcd_next;
          r_bin    <= r_bin << 1;
          r_bitcnt <= r_bitcnt + 1'b1;
        end
      end else if (r_state == ST_COMMIT) begin
        for (int p = 0; p < NUM_PLAYERS; p++) r_disp[p] <= r_shadow[p];
      end
    end
  end

  always_ff @(posedge clk7_159) begin
    if (reset) begin
      r_frame_cnt <= '0;
      r_hidden    <= 1'b0;
    end else begin
      if (w_vb_rise) r_frame_cnt <= w_frame_wrap ? '0 : r_frame_cnt + 1'b1;
      if (!blink_en)                   r_hidden <= 1'b0;
      else if (w_vb_rise && w_frame_wrap) r_hidden <= ~r_hidden;
    end
  end

  assign w_dy   = $signed({7'd0, vcnt}) - YC;
  assign w_w    = w_dy >>> SCALE_LOG2;
  assign w_in_y = !w_dy[15] && (w_w < 16'sd32);

  generate
    for (genvar gi = 0; gi < NUM_PLAYERS; gi++) begin : g_player
      logic [DIGITS-1:0] w_lz;
      logic [DIGITS-1:0] w_hit;
      for (genvar gj = 0; gj < DIGITS; gj++) begin : g_digit
        localparam logic signed [15:0] XC = 16'(X0 + gi*PLAYER_DX + gj*DIGIT_DX*S);
        localparam bit CAN_BLANK = (BLANK_LZ != 0) && (gj < DIGITS - 1);
        logic [3:0]         w_dig;
        logic signed [15:0] w_dx, w_u;
        logic               w_ul, w_ur, w_blank;
        logic [6:0]         w_seg;

        assign w_dig = r_disp[gi][4*(DIGITS-1-gj) +: 4];
        if (gj == 0) begin : g_lz0
          assign w_lz[gj] = (w_dig == 4'd0);
        end else begin : g_lzn
          assign w_lz[gj] = w_lz[gj-1] && (w_dig == 4'd0);
        end
        assign w_blank = CAN_BLANK && w_lz[gj];

        assign w_dx = $signed({7'd0, hcnt}) - XC;
        assign w_u  = w_dx >>> SCALE_LOG2;
        assign w_ul = (w_u < 16'sd4);
        assign w_ur = (w_u >= 16'sd12);
        assign w_seg = {(w_w >= 16'sd14) && (w_w < 16'sd18),
                        w_ul && (w_w < 16'sd16),
                        w_ul && (w_w >= 16'sd16),
                        (w_w >= 16'sd28),
                        w_ur && (w_w >= 16'sd16),
                        w_ur && (w_w < 16'sd16),
                        (w_w < 16'sd4)};
        assign w_hit[gj] = !w_dx[15] && (w_u < 16'sd16) && w_in_y && !w_blank &&
                           |(f_seg7(w_dig) & w_seg);
      end
      assign w_player_hit[gi] = |w_hit;
    end
  endgenerate

  always_ff @(posedge clk7_159) begin
    if (reset) score <= 1'b0;
    else       score <= (|w_player_hit) && !(blink_en && r_hidden);
  end

endmodule

// File: doc/score_display_renderer.md
Name: score_display_renderer

Overview:
Parametrised successor to the fixed two-digit score segment-to-video logic. It takes binary player scores, converts them to BCD with a sequential double-dabble engine, and decodes them to 7-segment form. It renders a scalable multi-player, multi-digit score overlay from the h/v counters. Score updates are double-buffered to vblank, with optional leading-zero blanking and game-over blink. It sits between the score counters and the video mixer.

Parameters:
NUM_PLAYERS, 2, number of independent score fields
SCORE_W, 7, binary width of each player score
DIGITS, 2, decimal digits shown per player
SCALE_LOG2, 0, pixel scale S = 2^SCALE_LOG2; cell is 16S wide x 32S tall
X0, 128, left pixel of player 0, digit 0 (most significant)
PLAYER_DX, 192, horizontal pitch between players (pixels)
DIGIT_DX, 32, horizontal pitch between digits, in units of S
Y0, 32, top pixel line of all digits
BLANK_LZ, 1, 1 = blank leading zeros (the least significant digit is always shown)
BLINK_FRAMES, 16, frames per blink half-period

Ports:
clk7_159  in  1  pixel clock
reset  in  1  synchronous, active-high
hcnt  in  9  current horizontal pixel count
vcnt  in  9  current line count
vblank  in  1  vertical blank level
score_in  in  NUM_PLAYERS*SCORE_W  packed binary scores, player 0 in LSBs
score_load  in  1  one-cycle request to display score_in
blink_en  in  1  level; 1 = overlay blinks (game over)
busy  out  1  capture/conversion in progress
score  out  1  registered score video bit

Behaviour:
- Reset: display digits = all 0, pending = 0, FSM = IDLE, frame counter = 0, blink phase = visible, busy = 0, score = 0. A reset during conversion aborts the conversion and discards captured scores.
- score_load sets the pending flag. A load while busy or while pending is already set also sets pending; the latest score_in is the value captured.
- FSM IDLE: on a vblank rising edge (registered vblank 0->1) with pending = 1, capture all score_in, clear pending, and go to CONV with player index 0.
- FSM CONV: shift-add-3 double dabble for one player. Each cycle adds 3 to every BCD nibble >= 5, then shifts in one binary bit MSB-first. After SCORE_W cycles, store the result in the shadow register, advance the player index, and restart. After the last player, go to COMMIT.
- FSM COMMIT: copy all shadow digits to the display registers in one cycle, then return to IDLE. busy = 1 in CONV and COMMIT.
- Saturation: if a value exceeds 10^DIGITS-1, that player shows all 9s (2 digits: 150 -> 99).
- Total latency from the vblank edge to display update = NUM_PLAYERS*SCORE_W+1 cycles. It must be shorter than vblank; the display never changes mid-active-frame.
- Segment geometry: for the digit at x0 = X0 + p*PLAYER_DX + k*DIGIT_DX*S, u = (hcnt-x0)>>SCALE_LOG2 and w = (vcnt-Y0)>>SCALE_LOG2. The digit is inside when 0<=u<16 and 0<=w<32. Segments:
  - a: w<4
  - g: 14<=w<18
  - d: w>=28
  - f: u<4 & w<16
  - b: u>=12 & w<16
  - e: u<4 & w>=16
  - c: u>=12 & w>=16
- Standard 7-seg encoding: 0 lights abcdef, 1 lights bc, 7 lights abc.
- Leading-zero blanking (BLANK_LZ=1): digit k is blank if all digits 0..k are zero and k<DIGITS-1.
- Blink: the frame counter increments on each vblank rising edge and wraps at BLINK_FRAMES-1, toggling the phase on wrap. With blink_en=1 and phase hidden, score=0. blink_en=0 forces the visible phase, counter free-running.
- Output: score = registered OR of all lit segments. Latency is one clock from hcnt/vcnt.
- Overlapping cells are illegal configuration; no priority is defined.

Test Plan:
- Reset, then set hcnt=X0, vcnt=Y0 -> score=0 before reset release; after release, the 00 display with BLANK_LZ=0 gives score=1 one cycle after the pixel lands on segment a.
- Load scores {12,7}, pulse score_load mid-frame -> display unchanged until the vblank edge. busy is high for 2*7 cycles, then 1 COMMIT cycle. P0 shows "7" with the tens digit blank; P1 shows "12".
- score_in=150 on P0 (SCORE_W=8, DIGITS=2) -> P0 displays 99. Scan the g-segment row -> score=1 on both digits.
- Two score_load pulses with different values before vblank -> only the second value is displayed.
- Assert reset during CONV -> busy=0 next cycle, display stays 0. After a new load and vblank, the correct score appears.
- blink_en=1, BLINK_FRAMES=2 -> score is suppressed on alternate 2-frame periods at a lit pixel. blink_en=0 -> always visible.
- SCALE_LOG2=1 -> segment a spans 8 lines and the digit spans 32 pixels.
